muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MULDIV_FASTMUL_EN: multiplies complete in one cycle; divides stay iterative.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;
`ifdef MULDIV_FASTMUL_EN
  logic [2*WIDTH-1:0]   fast_a, fast_b;
`endif

  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    b_mag     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

    // Shift-add: low half holds the remaining multiplier bits, product grows from the top.
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, p_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, low half shifts in quotient bits.
    shifted  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, b_q});
    diff     = shifted[WIDTH-1:0] - b_q;
    div_next = ge ? {diff, p_q[WIDTH-2:0], 1'b1}
                  : {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};

    prod = neg_q  ? -p_q : p_q;
    quo  = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FASTMUL_EN
    fast_a = {{WIDTH{1'b0}}, a_mag};
    fast_b = {{WIDTH{1'b0}}, b_mag};
`endif

    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          busy_d   = 1'b1;
          is_div_d = op[1];
          neg_d    = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          rneg_d   = is_signed & srca[WIDTH-1];
          dz_d     = (srcb == '0);
          a_d      = srca;
          b_d      = b_mag;
          p_d      = {{WIDTH{1'b0}}, a_mag};
`ifdef MULDIV_FASTMUL_EN
          if (!op[1]) begin
            state_d = S_FIX;
            p_d     = fast_a * fast_b;
          end
`endif
        end else begin
          if (mthi) hi_d = srca;
          if (mtlo) lo_d = srca;
        end
      end
      S_RUN: begin
        p_d   = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      b_q      <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      b_q      <= b_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; honours MULDIV_FASTMUL_EN for multiply latency.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb;
  logic         mthi, mtlo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a start at the next negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int elat);
    int cyc;
    launch(o, a, b);
    wait_done(0, cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(elat));
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1; start = 1'b0; op = '0; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
    run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_z", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT);

    // start while busy must not disturb the running op nor queue a second one
    launch(OP_DIVU, 32'd100, 32'd7);
    chk("busy_accept", 64'(busy), 64'd1);
    start = 1'b1; op = OP_MULTU; srca = 32'd2; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc);
    chk("ign_lat", 64'(cyc), 64'(DIV_LAT));
    chk("ign_hi", 64'(hi), 64'd2);
    chk("ign_lo", 64'(lo), 64'd14);
    count_done(40, pulses);
    chk("ign_no_second", 64'(pulses), 64'd0);

    launch(OP_DIVU, 32'd50, 32'd6);
    repeat (3) @(negedge clk);
    mtlo = 1'b1; srca = 32'h0000_DEAD;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_busy_lo", 64'(lo), 64'd14);
    wait_done(4, cyc);
    chk("mtlo_busy_lat", 64'(cyc), 64'(DIV_LAT));
    chk("mtlo_busy_res_lo", 64'(lo), 64'd8);
    chk("mtlo_busy_res_hi", 64'(hi), 64'd2);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; srca = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mv_hi", 64'(hi), 64'h1234_5678);
    chk("mv_lo", 64'(lo), 64'h1234_5678);
    chk("mv_done", 64'(done), 64'd0);

    @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = OP_DIVU; srca = 32'd9; srcb = 32'd4;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("stmv_hi_kept", 64'(hi), 64'h1234_5678);
    wait_done(0, cyc);
    chk("stmv_lat", 64'(cyc), 64'(DIV_LAT));
    chk("stmv_hi", 64'(hi), 64'd1);
    chk("stmv_lo", 64'(lo), 64'd2);

    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    count_done(40, pulses);
    chk("rst_mid_no_done", 64'(pulses), 64'd0);
    chk("rst_mid_lo_hold", 64'(lo), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
